// File: rtl/gpu_clk_enable_gen.sv
// Clock-enable generator: NUM_CH phase-aligned strobes with programmable period and
// phase, gated by a settle sequence that restarts on every accepted reconfiguration.
module gpu_clk_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int RST_DIV     = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] en_out,
  output logic              locked
);

  // state   | meaning
  // LOCKING | settle counter running, strobes gated, cfg not accepted
  // LOCKED  | channel counters running, strobes valid, cfg accepted

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = (RST_DIV < 1) ? DIV_W'(1) : DIV_W'(RST_DIV);
  localparam logic [CH_W:0]    NUM_CH_V = NUM_CH[CH_W:0];

  typedef enum logic {LOCKING, LOCKED} state_t;

  state_t             state;
  logic [SET_W-1:0]   settle;
  logic [DIV_W-1:0]   div_q   [NUM_CH];
  logic [DIV_W-1:0]   phase_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_q   [NUM_CH];
  logic [DIV_W-1:0]   cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  en_nxt;
  logic               xfer;
  logic               ch_ok;
  logic [DIV_W-1:0]   new_div;
  logic [DIV_W-1:0]   new_phase;

  assign cfg_ready = (state == LOCKED);

  // Stored div/phase are always legal, so the wrap compare never underflows.
  always_comb begin
    xfer      = cfg_valid && cfg_ready;
    ch_ok     = ({1'b0, cfg_ch} < NUM_CH_V);
    new_div   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    new_phase = (cfg_phase >= new_div) ? new_div - 1'b1 : cfg_phase;
    en_nxt    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en_nxt[i]  = (cnt_q[i] == phase_q[i]);
      cnt_nxt[i] = (cnt_q[i] == div_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state   <= LOCKING;
      settle  <= '0;
      locked  <= 1'b0;
      en_out  <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_RST;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      cfg_err <= xfer && !ch_ok;
      case (state)
        LOCKING: begin
          // Counters sit at 0 here, so the lock edge evaluates strobe index 0.
          if (settle == SET_LAST) begin
            state  <= LOCKED;
            locked <= 1'b1;
            settle <= '0;
            en_out <= en_nxt;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
          end else begin
            settle <= settle + 1'b1;
          end
        end
        LOCKED: begin
          if (xfer && ch_ok) begin
            state  <= LOCKING;
            locked <= 1'b0;
            en_out <= '0;
            settle <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              cnt_q[i] <= '0;
              if (cfg_ch == CH_W'(i)) begin
                div_q[i]   <= new_div;
                phase_q[i] <= new_phase;
              end
            end
          end else begin
            en_out <= en_nxt;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
          end
        end
        default: state <= LOCKING;
      endcase
    end
  end

endmodule
